// File: rtl/pynq_ov7670_pkg.sv
// pynq_ov7670_pkg: shared FSM states, RGB565 field map, colour bars and sizing helper
package pynq_ov7670_pkg;
  typedef enum logic [1:0] {SKIP, WAIT_FRAME, ACTIVE} state_t;
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;
  // {r,g,b} full-scale flags, index 0 = white ... index 7 = black
  localparam logic [7:0][2:0] COLOUR_BARS = {3'b000, 3'b001, 3'b100, 3'b101,
                                             3'b010, 3'b011, 3'b110, 3'b111};
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rgb565_expand.sv
// rgb565_expand: widens RGB565 fields to BIT_WIDTH by MSB replication (truncates when narrower)
module rgb565_expand
  import pynq_ov7670_pkg::*;
#(
  parameter int BIT_WIDTH = 8
)(
  input  logic [15:0]          pix,
  output logic [BIT_WIDTH-1:0] r,
  output logic [BIT_WIDTH-1:0] g,
  output logic [BIT_WIDTH-1:0] b
);
  logic [14:0] r_rep, b_rep;
  logic [11:0] g_rep;
  assign r_rep = {3{pix[R_MSB:R_LSB]}};
  assign g_rep = {2{pix[G_MSB:G_LSB]}};
  assign b_rep = {3{pix[B_MSB:B_LSB]}};
  assign r = r_rep[14 -: BIT_WIDTH];
  assign g = g_rep[11 -: BIT_WIDTH];
  assign b = b_rep[14 -: BIT_WIDTH];
endmodule

// File: rtl/ov7670_rgb565_capture.sv
// ov7670_rgb565_capture: OV7670 RGB565 byte stream to expanded pixels; OV7670_CAPTURE_TEST_PATTERN_EN selects colour bars
module ov7670_rgb565_capture
  import pynq_ov7670_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAME_WIDTH = 640,
  parameter int SKIP_FRAMES = 2,
  localparam int V_BITW = clog2(FRAME_HEIGHT),
  localparam int H_BITW = clog2(FRAME_WIDTH),
  localparam int P_BITW = clog2(FRAME_HEIGHT * FRAME_WIDTH)
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cam_vsync,
  input  logic                 cam_href,
  input  logic [7:0]           cam_data,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_r,
  output logic [BIT_WIDTH-1:0] out_g,
  output logic [BIT_WIDTH-1:0] out_b,
  output logic [V_BITW-1:0]    out_vcnt,
  output logic [H_BITW-1:0]    out_hcnt,
  output logic [P_BITW-1:0]    out_addr,
  output logic                 out_frame_done,
  output logic                 out_err
);
  localparam logic [V_BITW:0] FH = (V_BITW + 1)'(FRAME_HEIGHT);
  localparam logic [H_BITW:0] FW = (H_BITW + 1)'(FRAME_WIDTH);
  localparam logic [P_BITW:0] LINE_STEP = (P_BITW + 1)'(FRAME_WIDTH);
  logic vs_q, hr_q, vs_p, hr_p;
  logic [7:0] d_q, hi;
  state_t state;
  logic [3:0] skip_cnt;
  logic phase, done, fd_pend;
  logic [V_BITW:0] vcnt;
  logic [H_BITW:0] hcnt;
  logic [P_BITW:0] addr, line_base;
  logic [15:0] pix;
  logic [BIT_WIDTH-1:0] exp_r, exp_g, exp_b;
  logic vs_rise, vs_fall, hr_fall, in_frame, in_line, last;
  assign vs_rise = vs_q & ~vs_p;
  assign vs_fall = ~vs_q & vs_p;
  assign hr_fall = ~hr_q & hr_p;
  assign in_frame = vcnt < FH;
  assign in_line = hcnt < FW;
  assign last = (vcnt == FH - 1'b1) && (hcnt == FW - 1'b1);
`ifdef OV7670_CAPTURE_TEST_PATTERN_EN
  logic [2:0] bar, rgb;
  assign bar = 3'((32'(hcnt) * 8) / FRAME_WIDTH);
  assign rgb = COLOUR_BARS[bar];
  assign pix = {{5{rgb[2]}}, {6{rgb[1]}}, {5{rgb[0]}}};
`else
  assign pix = {hi, d_q};
`endif
  rgb565_expand #(.BIT_WIDTH(BIT_WIDTH)) u_expand (
    .pix(pix),
    .r(exp_r),
    .g(exp_g),
    .b(exp_b)
  );
  // register camera pins once, keep previous sync levels for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vs_q <= 1'b0;
      hr_q <= 1'b0;
      d_q <= '0;
      vs_p <= 1'b0;
      hr_p <= 1'b0;
    end else begin
      vs_q <= cam_vsync;
      hr_q <= cam_href;
      d_q <= cam_data;
      vs_p <= vs_q;
      hr_p <= hr_q;
    end
  end
  // frame sequencing, byte pairing, counters and registered pixel outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SKIP;
      skip_cnt <= '0;
      phase <= 1'b0;
      hi <= '0;
      done <= 1'b0;
      fd_pend <= 1'b0;
      vcnt <= '0;
      hcnt <= '0;
      addr <= '0;
      line_base <= '0;
      out_valid <= 1'b0;
      out_r <= '0;
      out_g <= '0;
      out_b <= '0;
      out_vcnt <= '0;
      out_hcnt <= '0;
      out_addr <= '0;
      out_frame_done <= 1'b0;
      out_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      fd_pend <= 1'b0;
      out_frame_done <= fd_pend;
      case (state)
        SKIP: begin
          if (skip_cnt >= 4'(SKIP_FRAMES)) state <= WAIT_FRAME;
          else if (vs_rise) skip_cnt <= skip_cnt + 4'd1;
        end
        WAIT_FRAME: begin
          if (vs_fall) begin
            state <= ACTIVE;
            phase <= 1'b0;
            done <= 1'b0;
            vcnt <= '0;
            hcnt <= '0;
            addr <= '0;
            line_base <= '0;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            state <= WAIT_FRAME;
            if (!done) out_err <= 1'b1;
          end else if (hr_q) begin
            phase <= ~phase;
            if (!phase) hi <= d_q;
            else if (in_line) begin
              hcnt <= hcnt + 1'b1;
              if (in_frame) begin
                out_valid <= 1'b1;
                out_r <= exp_r;
                out_g <= exp_g;
                out_b <= exp_b;
                out_vcnt <= V_BITW'(vcnt);
                out_hcnt <= H_BITW'(hcnt);
                out_addr <= P_BITW'(addr);
                addr <= addr + 1'b1;
                if (last) begin
                  fd_pend <= 1'b1;
                  done <= 1'b1;
                end
              end
            end
          end else if (hr_fall) begin
            phase <= 1'b0;
            hcnt <= '0;
            if (phase || (in_frame && in_line)) out_err <= 1'b1;
            if (in_frame) begin
              vcnt <= vcnt + 1'b1;
              addr <= line_base + LINE_STEP;
              line_base <= line_base + LINE_STEP;
            end
          end
        end
        default: state <= SKIP;
      endcase
    end
  end
endmodule

// File: doc/ov7670_rgb565_capture.md
Name: ov7670_rgb565_capture

Overview:
- Camera-side front end of the pynq_ov7670 pixel pipeline; sits directly upstream of the RGB→YCbCr converter and feeds it.
- Runs on the camera pixel clock. Takes the OV7670 8-bit RGB565 byte stream (VSYNC/HREF/D[7:0]) and assembles byte pairs into pixels.
- Expands each pixel to BIT_WIDTH-bit R/G/B and emits it with matching vcnt, hcnt and linear address.

Parameters:
- BIT_WIDTH, 8, output component width; must be in [6, 12].
- FRAME_HEIGHT, 480, active lines captured per frame.
- FRAME_WIDTH, 640, active pixels captured per line.
- SKIP_FRAMES, 2, frames discarded after reset while the sensor settles; range 0..15.

Ports:
- clock  in  1  camera pixel clock (PCLK); all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cam_vsync  in  1  OV7670 VSYNC; high = vertical blanking / frame start.
- cam_href  in  1  OV7670 HREF; high = active line bytes on cam_data.
- cam_data  in  8  OV7670 D[7:0]; first byte {R5,G6[5:3]}, second byte {G6[2:0],B5}.
- out_valid  in→out  out  1  one-cycle strobe; pixel outputs valid this cycle.
- out_r, out_g, out_b  out  BIT_WIDTH each  expanded colour components.
- out_vcnt  out  V_BITW  line index, 0..FRAME_HEIGHT-1.
- out_hcnt  out  H_BITW  pixel index, 0..FRAME_WIDTH-1.
- out_addr  out  P_BITW  linear address, vcnt*FRAME_WIDTH + hcnt.
- out_frame_done  out  1  one-cycle pulse after the last pixel of a complete frame.
- out_err  out  1  sticky error flag; cleared only by reset.

Width rule: V_BITW, H_BITW and P_BITW are ceil(log2) of FRAME_HEIGHT, FRAME_WIDTH and FRAME_HEIGHT*FRAME_WIDTH.

Behaviour:
- Reset (asynchronous): all outputs 0, state SKIP, byte phase 0, skip counter 0.
- Input registering: cam_vsync, cam_href and cam_data are registered once before use. Output latency is 2 clocks from the second byte on the pins to out_valid.
- State machine:
  - SKIP: count VSYNC rising edges. Move to WAIT_FRAME when the count reaches SKIP_FRAMES. With SKIP_FRAMES=0, go straight to WAIT_FRAME.
  - WAIT_FRAME: wait for a VSYNC falling edge, then clear counters and go to ACTIVE.
  - ACTIVE: capture pixels as below. A VSYNC rising edge goes to WAIT_FRAME.
- Pixel assembly in ACTIVE:
  - While HREF is high, byte phase toggles every clock.
  - Phase 0 latches the first byte. Phase 1 forms the pixel and asserts out_valid for one cycle.
  - Expansion uses MSB replication, e.g. BIT_WIDTH=8 gives R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - For BIT_WIDTH<field width, the component is truncated to its MSBs.
- Counters:
  - hcnt increments after each emitted pixel.
  - Pixels with hcnt ≥ FRAME_WIDTH are dropped: no out_valid, and hcnt saturates.
  - On HREF falling: hcnt←0, phase←0, vcnt increments. Lines with vcnt ≥ FRAME_HEIGHT are dropped.
  - out_addr is kept incrementally (+1 per pixel), with no multiplier.
- Frame done: out_frame_done pulses in the cycle after the pixel at (FRAME_HEIGHT-1, FRAME_WIDTH-1) is emitted.
- out_err is set on any of:
  - HREF falls with phase 1 (odd byte count); the partial pixel is discarded.
  - A line ends with fewer than FRAME_WIDTH pixels.
  - VSYNC rises in ACTIVE before frame done.
- Simultaneous events: VSYNC rising and HREF high in the same cycle — VSYNC wins; the pixel is discarded.
- HREF while in SKIP or WAIT_FRAME is ignored.

Optional Feature:
- Macro: OV7670_CAPTURE_TEST_PATTERN_EN.
- Defined: cam_data is ignored. Pixels come from an internal 8-bar colour pattern with bar = hcnt*8/FRAME_WIDTH, giving white, yellow, cyan, green, magenta, red, blue, black at full scale. Timing is still driven by cam_vsync and cam_href.
- Undefined: camera data is used and no pattern logic is synthesised.

Decomposition:
- Shared package pynq_ov7670_pkg holds:
  - the state enum (SKIP, WAIT_FRAME, ACTIVE);
  - the log2 function;
  - the RGB565 field positions;
  - the colour-bar constants.
- One sub-module: rgb565_expand, combinational, parameterised by BIT_WIDTH. It is used for both the camera path and the pattern path.

Test Plan:
- SKIP_FRAMES=2, 3 VSYNC pulses, 4x4 frame → no out_valid until after the 2nd VSYNC pulse; frame 3 yields 16 strobes with addr 0..15.
- Byte pair 0xF8,0x00 → out_r=0xFF, out_g=0x00, out_b=0x00. Byte pair 0x07,0xE0 → out_g=0xFF. Byte pair 0x00,0x1F → out_b=0xFF.
- FRAME_WIDTH=4 with a 6-pixel line → exactly 4 strobes with hcnt 0..3. Next line gives vcnt=1, hcnt=0, addr=4.
- HREF low after 7 bytes → 3 pixels emitted, out_err=1, next line starts clean.
- VSYNC rises mid-frame → capture aborts, no out_frame_done, out_err=1; the next full frame produces an out_frame_done pulse.
- Reset asserted mid-line → outputs 0 immediately (asynchronous); after release the state is SKIP.
